// File: rtl/mem_store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_store_buffer
// Brief   : In-order committed-store buffer with same-word merge and load
//           forwarding/stall, feeding the DCache / uncached write path.
// Rev     : 1.0  initial release
// ============================================================================
module mem_store_buffer #(
  parameter  int DEPTH    = 4,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int MERGE_EN = 1,
  parameter  int FWD_EN   = 1,
  localparam int STRB_W   = DATA_W / 8,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [STRB_W-1:0] st_wstrb,
  input  logic              st_uncached,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic              bus_uncached,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [STRB_W-1:0] ld_strb,
  input  logic              ld_uncached,
  output logic              ld_stall,
  output logic              ld_fwd,
  output logic [DATA_W-1:0] ld_fwd_data,
  output logic [CNT_W-1:0]  sb_count,
  output logic              sb_empty,
  output logic              sb_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(STRB_W);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [STRB_W-1:0] r_strb [DEPTH];
  logic [DEPTH-1:0]  r_unc;
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_young;
  logic              w_merge_hit;
  logic              w_push;
  logic              w_alloc;
  logic              w_pop;
  logic [PTR_W-1:0]  w_idx;
  logic              w_conflict;
  logic [STRB_W-1:0] w_y_strb;
  logic [DATA_W-1:0] w_y_data;
  logic              w_y_unc;
  logic              w_unused;

  assign w_unused = ^{st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

  assign sb_count  = r_count;
  assign sb_empty  = (r_count == '0);
  assign sb_full   = (r_count == CNT_W'(DEPTH));
  assign bus_valid = !sb_empty;

  assign bus_addr     = r_addr[r_head];
  assign bus_wdata    = r_data[r_head];
  assign bus_wstrb    = r_strb[r_head];
  assign bus_uncached = r_unc[r_head];

  // With two or more entries the youngest can never be the head.
  assign w_young     = r_tail - PTR_W'(1);
  assign w_merge_hit = (MERGE_EN != 0) && (r_count >= CNT_W'(2)) &&
                       r_vld[w_young] && !r_unc[w_young] && !st_uncached &&
                       (r_addr[w_young][ADDR_W-1:OFF_W] == st_addr[ADDR_W-1:OFF_W]);

  assign st_ready = !sb_full || w_merge_hit;
  assign w_push   = st_valid && st_ready;
  assign w_alloc  = w_push && !w_merge_hit;
  assign w_pop    = bus_valid && bus_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_head        <= r_head + PTR_W'(1);
        r_vld[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_tail        <= r_tail + PTR_W'(1);
        r_vld[r_tail] <= 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      r_data[r_tail] <= st_wdata;
      r_strb[r_tail] <= st_wstrb;
      r_unc[r_tail]  <= st_uncached;
    end else if (w_push) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (st_wstrb[b]) r_data[w_young][8*b +: 8] <= st_wdata[8*b +: 8];
      end
      r_strb[w_young] <= r_strb[w_young] | st_wstrb;
    end
  end

  // Scan oldest to youngest so the last overlapping entry wins.
  always_comb begin
    w_idx      = r_head;
    w_conflict = 1'b0;
    w_y_strb   = '0;
    w_y_data   = '0;
    w_y_unc    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_vld[w_idx] &&
          (r_addr[w_idx][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]) &&
          ((r_strb[w_idx] & ld_strb) != '0)) begin
        w_conflict = 1'b1;
        w_y_strb   = r_strb[w_idx];
        w_y_data   = r_data[w_idx];
        w_y_unc    = r_unc[w_idx];
      end
    end
  end

  assign ld_fwd      = (FWD_EN != 0) && ld_valid && !ld_uncached && w_conflict &&
                       !w_y_unc && ((w_y_strb & ld_strb) == ld_strb);
  assign ld_fwd_data = w_y_data;
  assign ld_stall    = ld_valid && ((ld_uncached && !sb_empty) || (w_conflict && !ld_fwd));

endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mem_store_buffer
// Brief   : Directed + randomized bench for mem_store_buffer against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st_valid, st_uncached, bus_ready, ld_valid, ld_uncached;
  logic [31:0] st_addr, st_wdata, ld_addr;
  logic [3:0]  st_wstrb, ld_strb;

  logic        st_ready, bus_valid, bus_uncached, ld_stall, ld_fwd, sb_empty, sb_full;
  logic [31:0] bus_addr, bus_wdata, ld_fwd_data;
  logic [3:0]  bus_wstrb;
  logic [2:0]  sb_count;

  logic        n_st_ready, n_bus_valid, n_bus_uncached, n_ld_stall, n_ld_fwd, n_sb_empty, n_sb_full;
  logic [31:0] n_bus_addr, n_bus_wdata, n_ld_fwd_data;
  logic [3:0]  n_bus_wstrb;
  logic [2:0]  n_sb_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(DEPTH), .MERGE_EN(1), .FWD_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_wstrb(st_wstrb), .st_uncached(st_uncached),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_uncached(bus_uncached),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_strb(ld_strb), .ld_uncached(ld_uncached),
    .ld_stall(ld_stall), .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data),
    .sb_count(sb_count), .sb_empty(sb_empty), .sb_full(sb_full)
  );

  // Same stimulus, forwarding disabled.
  mem_store_buffer #(.DEPTH(DEPTH), .MERGE_EN(1), .FWD_EN(0)) dut_nf (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(n_st_ready), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_wstrb(st_wstrb), .st_uncached(st_uncached),
    .bus_valid(n_bus_valid), .bus_ready(bus_ready), .bus_addr(n_bus_addr), .bus_wdata(n_bus_wdata),
    .bus_wstrb(n_bus_wstrb), .bus_uncached(n_bus_uncached),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_strb(ld_strb), .ld_uncached(ld_uncached),
    .ld_stall(n_ld_stall), .ld_fwd(n_ld_fwd), .ld_fwd_data(n_ld_fwd_data),
    .sb_count(n_sb_count), .sb_empty(n_sb_empty), .sb_full(n_sb_full)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        unc;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  function automatic bit m_merge();
    if (q.size() < 2) return 1'b0;
    return !q[q.size()-1].unc && !st_uncached && same_word(q[q.size()-1].addr, st_addr);
  endfunction

  function automatic bit m_ready();
    return (q.size() < DEPTH) || m_merge();
  endfunction

  task automatic m_load(input bit fwd_en, output bit stall, output bit fwd, output logic [31:0] data);
    bit   conflict = 1'b0;
    ent_t y;
    y = '{addr: '0, data: '0, strb: '0, unc: 1'b0};
    foreach (q[i]) begin
      if (same_word(q[i].addr, ld_addr) && ((q[i].strb & ld_strb) != 0)) begin
        conflict = 1'b1;
        y = q[i];
      end
    end
    fwd   = fwd_en && ld_valid && !ld_uncached && conflict && !y.unc && ((y.strb & ld_strb) == ld_strb);
    data  = y.data;
    stall = ld_valid && ((ld_uncached && q.size() != 0) || (conflict && !fwd));
  endtask

  always @(negedge resetn) q.delete();

  always @(posedge clk) begin
    if (resetn) begin
      bit pop, mrg, push;
      pop  = (q.size() != 0) && bus_ready;
      mrg  = m_merge();
      push = st_valid && m_ready();
      if (push && mrg) begin
        for (int b = 0; b < 4; b++)
          if (st_wstrb[b]) q[q.size()-1].data[8*b +: 8] = st_wdata[8*b +: 8];
        q[q.size()-1].strb = q[q.size()-1].strb | st_wstrb;
      end else if (push) begin
        q.push_back('{addr: {st_addr[31:2], 2'b00}, data: st_wdata, strb: st_wstrb, unc: st_uncached});
      end
      if (pop) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    bit e_stall, e_fwd, e_nstall, e_nfwd;
    logic [31:0] e_data, e_ndata;
    m_load(1'b1, e_stall, e_fwd, e_data);
    m_load(1'b0, e_nstall, e_nfwd, e_ndata);
    chk("count", sb_count, q.size());
    chk("empty", sb_empty, q.size() == 0);
    chk("full", sb_full, q.size() == DEPTH);
    chk("bus_valid", bus_valid, q.size() != 0);
    chk("st_ready", st_ready, m_ready());
    if (q.size() != 0) begin
      chk("bus_addr", bus_addr, q[0].addr);
      chk("bus_wdata", bus_wdata, q[0].data);
      chk("bus_wstrb", bus_wstrb, q[0].strb);
      chk("bus_unc", bus_uncached, q[0].unc);
    end
    chk("ld_stall", ld_stall, e_stall);
    chk("ld_fwd", ld_fwd, e_fwd);
    if (e_fwd) chk("ld_fwd_data", ld_fwd_data & {{8{ld_strb[3]}}, {8{ld_strb[2]}}, {8{ld_strb[1]}}, {8{ld_strb[0]}}},
                   e_data & {{8{ld_strb[3]}}, {8{ld_strb[2]}}, {8{ld_strb[1]}}, {8{ld_strb[0]}}});
    chk("nf_ld_stall", n_ld_stall, e_nstall);
    chk("nf_ld_fwd", n_ld_fwd, e_nfwd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 0; st_uncached = 0; st_addr = '0; st_wdata = '0; st_wstrb = 4'h1;
    ld_valid = 0; ld_uncached = 0; ld_addr = '0; ld_strb = 4'h1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1; st_addr = a; st_wdata = d; st_wstrb = s; st_uncached = 0;
    tick();
    st_valid = 0;
  endtask

  task automatic drain();
    bus_ready = 1;
    for (int k = 0; k < 20; k++) begin
      if (sb_empty) break;
      tick();
    end
    chk("drain_empty", sb_empty, 1);
    bus_ready = 0;
  endtask

  initial begin
    resetn = 0; bus_ready = 0;
    idle();
    repeat (3) tick();
    #1;
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", sb_empty, 1);
    chk("rst_full", sb_full, 0);
    chk("rst_count", sb_count, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_ld_fwd", ld_fwd, 0);
    tick();
    resetn = 1;
    tick();

    // single push then pop
    push(32'h100, 32'h11223344, 4'hF);
    #1;
    chk("t1_valid", bus_valid, 1);
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_data", bus_wdata, 32'h11223344);
    chk("t1_count", sb_count, 1);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("t1_empty", sb_empty, 1);

    // fill, full backpressure, pop does not free space same cycle
    push(32'h700, 32'h1, 4'hF);
    push(32'h710, 32'h2, 4'hF);
    push(32'h720, 32'h3, 4'hF);
    push(32'h730, 32'h4, 4'hF);
    st_valid = 1; st_addr = 32'h740; st_wdata = 32'h5; st_wstrb = 4'hF;
    #1;
    chk("t2_full", sb_full, 1);
    chk("t2_st_ready", st_ready, 0);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("t2_count_after_pop", sb_count, 3);
    chk("t2_ready_after_pop", st_ready, 1);
    tick();
    st_valid = 0;
    chk("t2_count_refill", sb_count, 4);
    chk("t2_head", bus_addr, 32'h710);
    drain();

    // merge into youngest non-head, not into head
    push(32'h200, 32'h00000011, 4'h1);
    push(32'h300, 32'h00000022, 4'h1);
    push(32'h300, 32'h0000AB00, 4'h2);
    #1;
    chk("t3_count", sb_count, 2);
    chk("t3_head", bus_addr, 32'h200);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("t3_merged_addr", bus_addr, 32'h300);
    chk("t3_merged_strb", bus_wstrb, 4'h3);
    chk("t3_merged_data", bus_wdata & 32'h0000FFFF, 32'h0000AB22);
    push(32'h300, 32'h00CD0000, 4'h4);
    #1;
    chk("t3_head_no_merge", sb_count, 2);
    drain();

    // forwarding vs FWD_EN=0
    push(32'h400, 32'hDEADBEEF, 4'hF);
    ld_valid = 1; ld_addr = 32'h400; ld_strb = 4'h3;
    #1;
    chk("t4_fwd", ld_fwd, 1);
    chk("t4_fwd_data", ld_fwd_data, 32'hDEADBEEF);
    chk("t4_stall", ld_stall, 0);
    chk("t4_nf_stall", n_ld_stall, 1);
    ld_valid = 0;
    drain();

    // partial overlap and uncached load hazards
    push(32'h500, 32'h00001234, 4'h3);
    ld_valid = 1; ld_addr = 32'h500; ld_strb = 4'hC;
    #1;
    chk("t5_disjoint_stall", ld_stall, 0);
    ld_strb = 4'h6;
    #1;
    chk("t5_partial_stall", ld_stall, 1);
    chk("t5_partial_fwd", ld_fwd, 0);
    ld_addr = 32'h600; ld_strb = 4'h1; ld_uncached = 1;
    #1;
    chk("t5_unc_stall", ld_stall, 1);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    chk("t5_unc_released", ld_stall, 0);
    idle();

    // async reset mid-drain
    push(32'h900, 32'hA, 4'hF);
    push(32'h910, 32'hB, 4'hF);
    push(32'h920, 32'hC, 4'hF);
    bus_ready = 1;
    tick();
    bus_ready = 0;
    #1;
    resetn = 0;
    #1;
    chk("t6_bus_valid", bus_valid, 0);
    chk("t6_count", sb_count, 0);
    tick();
    resetn = 1;
    push(32'hA00, 32'h77, 4'hF);
    chk("t6_restart_addr", bus_addr, 32'hA00);
    chk("t6_restart_count", sb_count, 1);
    drain();

    // randomized traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      st_valid    = $urandom_range(0, 1);
      st_addr     = 32'h800 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      st_wdata    = $urandom;
      st_wstrb    = 4'($urandom_range(1, 15));
      st_uncached = ($urandom_range(0, 4) == 0);
      bus_ready   = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ld_valid    = $urandom_range(0, 1);
      ld_addr     = 32'h800 + ($urandom_range(0, 3) << 2);
      ld_strb     = 4'($urandom_range(1, 15));
      ld_uncached = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #1 resetn = 0;
        #1 resetn = 1;
      end
      tick();
    end
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
